// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction fields, opcodes and the instruction-memory
// state encoding.
package cpu_pkg;

  localparam int unsigned OPC_W = 5;
  localparam int unsigned OPR_W = 12;

  localparam logic [OPC_W-1:0] OP_NOP   = 5'd28;
  localparam logic [OPC_W-1:0] OP_ENDOP = 5'd31;

  // Returned for out-of-range fetches so a runaway core halts.
  localparam logic [OPC_W+OPR_W-1:0] ENDOP_WORD = {OP_ENDOP, {OPR_W{1'b0}}};

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StRun  = 2'd2
  } imem_state_e;

endpackage

// File: rtl/instr_rd_port.sv
// One registered fetch port: range-checks the address against the loaded
// program length and substitutes the ENDOP word when it is out of range.
module instr_rd_port
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch,
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W:0]   prog_len,
  input  logic [DATA_W-1:0] ram_word,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_err
);

  logic              in_range;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              err_q;

  assign in_range = {1'b0, addr} < prog_len;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= fetch;
      // Data holds between fetches; the error flag follows the valid pulse.
      if (fetch) begin
        data_q <= in_range ? ram_word : DATA_W'(ENDOP_WORD);
        err_q  <= !in_range;
      end else begin
        err_q  <= 1'b0;
      end
    end
  end

  assign rd_data  = data_q;
  assign rd_valid = valid_q;
  assign rd_err   = err_q;

endmodule

// File: rtl/instr_mem_mp.sv
// Loadable multi-port instruction RAM: a loader streams a program in, then
// N_PORTS cores fetch from it in parallel through registered read ports.
module instr_mem_mp
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 17,
  parameter int unsigned DEPTH   = 2048,
  parameter int unsigned N_PORTS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load_start,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic [DATA_W-1:0]           ld_data,
  input  logic                        ld_last,
  output logic                        ld_done,
  output logic [ADDR_W:0]             prog_len,
  output logic [1:0]                  state,
  input  logic [N_PORTS-1:0]          rd_en,
  input  logic [N_PORTS*ADDR_W-1:0]   rd_addr,
  output logic [N_PORTS*DATA_W-1:0]   rd_data,
  output logic [N_PORTS-1:0]          rd_valid,
  output logic [N_PORTS-1:0]          rd_err
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  imem_state_e       state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W:0]   prog_len_q, prog_len_d;
  logic              ld_done_q, ld_done_d;
  logic              wr_en;
  logic              fetch_ok;

  logic [DATA_W-1:0] ram [DEPTH];

  assign ld_ready = (state_q == StLoad);
  // A restart in the same cycle wins over both the loader word and fetches.
  assign wr_en    = ld_ready && ld_valid && !load_start;
  assign fetch_ok = (state_q == StRun) && !load_start;

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    prog_len_d = prog_len_q;
    ld_done_d  = 1'b0;
    if (load_start) begin
      state_d    = StLoad;
      wptr_d     = '0;
      prog_len_d = '0;
    end else if (wr_en) begin
      wptr_d = wptr_q + ADDR_W'(1);
      if (ld_last || (wptr_q == ADDR_W'(DEPTH - 1))) begin
        state_d    = StRun;
        wptr_d     = '0;
        prog_len_d = {1'b0, wptr_q} + (ADDR_W + 1)'(1);
        ld_done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wptr_q     <= '0;
      prog_len_q <= '0;
      ld_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      prog_len_q <= prog_len_d;
      ld_done_q  <= ld_done_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ram[wptr_q[IdxW-1:0]] <= ld_data;
    end
  end

  assign ld_done  = ld_done_q;
  assign prog_len = prog_len_q;
  assign state    = state_q;

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] ram_word;

    assign addr     = rd_addr[p*ADDR_W +: ADDR_W];
    assign ram_word = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH)) ? ram[addr[IdxW-1:0]] : '0;

    instr_rd_port #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
    ) u_rd_port (
      .clk      (clk),
      .rst_n    (rst_n),
      .fetch    (fetch_ok && rd_en[p]),
      .addr     (addr),
      .prog_len (prog_len_q),
      .ram_word (ram_word),
      .rd_data  (rd_data[p*DATA_W +: DATA_W]),
      .rd_valid (rd_valid[p]),
      .rd_err   (rd_err[p])
    );
  end

endmodule
